scc_run_ctrl: RTL

- Hardware run controller for the scc_f25_top core. It takes over the stimulus/observer role for the core's control interface.
- Drives the core's reset and clock-enable, sequences a multi-cycle reset hold, then lets the core run.
- Monitors halt_f and err_bits, counts executed cycles, and enforces a cycle timeout.
- Latches the final run status and last observed bus values for an FPGA top level or debug register read-out.

---
 rtl/scc_pkg.sv | 19 +
 rtl/scc_run_cnt.sv | 48 ++++
 rtl/scc_run_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/scc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scc_pkg
// Purpose  : Shared run-controller state encoding and widths
// Revision : 1.0
// ============================================================================
package scc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ERR_W = 2;

endpackage
`default_nettype wire

// File: rtl/scc_run_cnt.sv
`default_nettype none
// ============================================================================
// Module   : scc_run_cnt
// Purpose  : Reset-hold down-counter plus saturating run-cycle up-counter
// Revision : 1.0
// ============================================================================
module scc_run_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_load,
  input  logic [7:0]       hold_val,
  input  logic             hold_dec,
  output logic             hold_zero,
  input  logic             cnt_clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [7:0]       r_hold;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold <= '0;
      r_cnt  <= '0;
    end else begin
      if (hold_load)
        r_hold <= hold_val;
      else if (hold_dec && (r_hold != 8'd0))
        r_hold <= r_hold - 8'd1;

      if (cnt_clr)
        r_cnt <= '0;
      else if (cnt_en)
        r_cnt <= cnt_nxt;
    end
  end

  // Saturate at all-ones so a very long run never wraps back to zero
  assign cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign cnt       = r_cnt;
  assign hold_zero = (r_hold == 8'd0);

endmodule
`default_nettype wire

// File: rtl/scc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scc_run_ctrl
// Purpose  : Sequences core reset, gates core clock, detects stop, latches status
// Revision : 1.0
// ============================================================================
module scc_run_ctrl
  import scc_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 3,
  parameter int TIMEOUT_CYCLES  = 500,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run_en,
  input  logic             core_halt_f,
  input  logic [ERR_W-1:0] core_err_bits,
  input  logic [31:0]      core_imem_v,
  input  logic [31:0]      core_dmem_v,
  output logic             core_rst,
  output logic             core_clk_en,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout_f,
  output logic [ERR_W-1:0] err_latched,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      last_instr,
  output logic [31:0]      last_dmem
);

  localparam logic [7:0]       c_hold_init = 8'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  logic             r_core_rst;
  logic             r_halted;
  logic             r_timeout;
  logic [ERR_W-1:0] r_err;
  logic [31:0]      r_last_instr;
  logic [31:0]      r_last_dmem;

  logic             w_launch;
  logic             w_run_step;
  logic             w_hold_zero;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_launch   = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_run_step = (r_state == RUN) && run_en;

  scc_run_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .hold_load (w_launch),
    .hold_val  (c_hold_init),
    .hold_dec  (r_state == RESET),
    .hold_zero (w_hold_zero),
    .cnt_clr   (w_launch),
    .cnt_en    (w_run_step),
    .cnt       (cycle_count),
    .cnt_nxt   (w_cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_core_rst   <= 1'b1;
      r_halted     <= 1'b0;
      r_timeout    <= 1'b0;
      r_err        <= '0;
      r_last_instr <= '0;
      r_last_dmem  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= RESET;
            r_core_rst   <= 1'b1;
            r_halted     <= 1'b0;
            r_timeout    <= 1'b0;
            r_err        <= '0;
            r_last_instr <= '0;
            r_last_dmem  <= '0;
          end
        end
        RESET: begin
          if (w_hold_zero) begin
            r_state    <= RUN;
            r_core_rst <= 1'b0;
          end
        end
        RUN: begin
          // Paused cycles neither advance the run nor evaluate stop conditions
          if (run_en) begin
            r_last_instr <= core_imem_v;
            r_last_dmem  <= core_dmem_v;
            if (core_halt_f) begin
              r_halted <= 1'b1;
              r_err    <= core_err_bits;
              r_state  <= DONE;
            end else if (core_err_bits != '0) begin
              r_err   <= core_err_bits;
              r_state <= DONE;
            end else if (w_cnt_nxt == c_timeout) begin
              r_timeout <= 1'b1;
              r_err     <= core_err_bits;
              r_state   <= DONE;
            end
          end
        end
      endcase
    end
  end

  assign core_rst    = r_core_rst;
  assign core_clk_en = (r_state == RESET) || w_run_step;
  assign busy        = (r_state == RESET) || (r_state == RUN);
  assign done        = (r_state == DONE);
  assign halted      = r_halted;
  assign timeout_f   = r_timeout;
  assign err_latched = r_err;
  assign last_instr  = r_last_instr;
  assign last_dmem   = r_last_dmem;

endmodule
`default_nettype wire
